// File: rtl/pipe_pkg.sv
// Shared definitions for the packet-processing pipeline.
//   - mode codes driven by the control/mode logic
//   - default thread count and per-thread PC width
//   - thread-id and PC types at the default widths
package pipe_pkg;

    typedef enum logic [1:0] {
        MODE_FIFO_IN  = 2'b00,
        MODE_FIFO_OUT = 2'b01,
        MODE_PROCESS  = 2'b10,
        MODE_IDLE     = 2'b11
    } mode_e;

    localparam int DEF_NUM_THREADS = 4;
    localparam int DEF_PC_W        = 7;
    localparam int DEF_TID_W       = $clog2(DEF_NUM_THREADS);

    typedef logic [DEF_TID_W-1:0] tid_t;
    typedef logic [DEF_PC_W-1:0]  pc_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : one request bit per thread
//   last   : most recently granted thread
//   gnt_oh : one-hot grant (all zero when nothing requests)
//   gnt_id : encoded grant (equals last when nothing requests)
//   any    : at least one request present
// Search starts at last+1 and wraps; last itself is the final candidate.
module rr_arbiter
    import pipe_pkg::*;
#(
    parameter int N    = DEF_NUM_THREADS,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic [N-1:0]    gnt_oh,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        idx    = '0;
        gnt_id = last;
        any    = |req;
        // Walk candidates from farthest to nearest so the nearest requester
        // after last is the one left standing. N is a power of two, so the
        // ID_W-bit add wraps modulo N for free.
        for (int k = N; k >= 1; k--) begin
            idx = last + ID_W'(k);
            if (req[idx]) begin
                gnt_id = idx;
            end
        end
        gnt_oh = '0;
        if (any) begin
            gnt_oh[gnt_id] = 1'b1;
        end
    end

endmodule

// File: rtl/thread_pc_scheduler.sv
// Per-thread PC bank with round-robin fetch issue.
//   clk, rst (sync, active-low)
//   run                 : issue enable from mode logic
//   start               : clear PCs/halts, restart rotation at thread 0
//   br_valid/tid/target : PC redirect for one thread
//   halt_valid/tid      : mark a thread finished
//   if_valid/tid/addr   : registered fetch slot, addr = {tid, pc}
//   active              : per-thread not-halted mask
//   all_done            : every thread halted
module thread_pc_scheduler
    import pipe_pkg::*;
#(
    parameter int NUM_THREADS = DEF_NUM_THREADS,
    parameter int PC_W        = DEF_PC_W,
    parameter int TID_W       = $clog2(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   start,
    input  logic                   br_valid,
    input  logic [TID_W-1:0]       br_tid,
    input  logic [PC_W-1:0]        br_target,
    input  logic                   halt_valid,
    input  logic [TID_W-1:0]       halt_tid,
    output logic                   if_valid,
    output logic [TID_W-1:0]       if_tid,
    output logic [TID_W+PC_W-1:0]  if_addr,
    output logic [NUM_THREADS-1:0] active,
    output logic                   all_done
);

    logic [PC_W-1:0]         pc_q [NUM_THREADS];
    logic [PC_W-1:0]         pc_d [NUM_THREADS];
    logic [NUM_THREADS-1:0]  halted_q, halted_d;
    logic [TID_W-1:0]        last_q, last_d;
    logic                    if_valid_q, if_valid_d;
    logic [TID_W-1:0]        if_tid_q, if_tid_d;
    logic [TID_W+PC_W-1:0]   if_addr_q, if_addr_d;

    logic [NUM_THREADS-1:0]  gnt_oh;
    logic [TID_W-1:0]        gnt_id;
    logic                    req_any;
    logic                    issue;

    rr_arbiter #(
        .N    (NUM_THREADS),
        .ID_W (TID_W)
    ) u_arb (
        .req    (~halted_q),
        .last   (last_q),
        .gnt_oh (gnt_oh),
        .gnt_id (gnt_id),
        .any    (req_any)
    );

    always_comb begin
        halted_d = halted_q;
        if (halt_valid) begin
            halted_d[halt_tid] = 1'b1;
        end

        // A halt that retires the last active thread also suppresses this
        // cycle's issue, so if_valid is already low when all_done rises.
        issue = run && req_any && !(&halted_d);

        pc_d       = pc_q;
        last_d     = last_q;
        if_valid_d = 1'b0;
        if_tid_d   = if_tid_q;
        if_addr_d  = if_addr_q;

        if (issue) begin
            if_valid_d = 1'b1;
            if_tid_d   = gnt_id;
            if_addr_d  = {gnt_id, pc_q[gnt_id]};
            last_d     = gnt_id;
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (gnt_oh[i]) begin
                    pc_d[i] = pc_q[i] + 1'b1;
                end
            end
        end

        // Applied after the increment so a same-cycle redirect wins.
        if (br_valid) begin
            pc_d[br_tid] = br_target;
        end

        if (start) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc_d[i] = '0;
            end
            halted_d   = '0;
            last_d     = TID_W'(NUM_THREADS - 1);
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc_q[i] <= '0;
            end
            halted_q   <= '0;
            last_q     <= TID_W'(NUM_THREADS - 1);
            if_valid_q <= 1'b0;
            if_tid_q   <= '0;
            if_addr_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc_q[i] <= pc_d[i];
            end
            halted_q   <= halted_d;
            last_q     <= last_d;
            if_valid_q <= if_valid_d;
            if_tid_q   <= if_tid_d;
            if_addr_q  <= if_addr_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_tid   = if_tid_q;
    assign if_addr  = if_addr_q;
    assign active   = ~halted_q;
    assign all_done = &halted_q;

endmodule

// File: tb/tb_thread_pc_scheduler.sv
module tb_thread_pc_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, run, br_valid, halt_valid;

    logic [1:0] br_tid4, halt_tid4;
    logic [6:0] br_tgt4;
    logic       v4, done4;
    logic [1:0] tid4;
    logic [8:0] addr4;
    logic [3:0] act4;

    logic [2:0] br_tid8, halt_tid8;
    logic [5:0] br_tgt8;
    logic       v8, done8;
    logic [2:0] tid8;
    logic [8:0] addr8;
    logic [7:0] act8;

    thread_pc_scheduler #(.NUM_THREADS(4), .PC_W(7)) dut4 (
        .clk(clk), .rst(rst), .run(run), .start(start),
        .br_valid(br_valid), .br_tid(br_tid4), .br_target(br_tgt4),
        .halt_valid(halt_valid), .halt_tid(halt_tid4),
        .if_valid(v4), .if_tid(tid4), .if_addr(addr4),
        .active(act4), .all_done(done4)
    );

    thread_pc_scheduler #(.NUM_THREADS(8), .PC_W(6)) dut8 (
        .clk(clk), .rst(rst), .run(run), .start(start),
        .br_valid(br_valid), .br_tid(br_tid8), .br_target(br_tgt8),
        .halt_valid(halt_valid), .halt_tid(halt_tid8),
        .if_valid(v8), .if_tid(tid8), .if_addr(addr8),
        .active(act8), .all_done(done8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 = 4-thread/7-bit, index 1 = 8-thread/6-bit
    int m_pc   [2][16];
    bit m_halt [2][16];
    int m_last [2];
    bit m_v    [2];
    int m_tid  [2];
    int m_addr [2];
    int m_n    [2] = '{4, 8};
    int m_pcw  [2] = '{7, 6};

    function automatic void m_reset(int m);
        for (int i = 0; i < 16; i++) begin
            m_pc[m][i] = 0;
            m_halt[m][i] = 0;
        end
        m_last[m] = m_n[m] - 1;
        m_v[m] = 0;
        m_tid[m] = 0;
        m_addr[m] = 0;
    endfunction

    function automatic void m_step(int m, bit st, bit r, bit bv, int bt, int btg, bit hv, int ht);
        int n, span, t;
        bit nh [16];
        bit any, will_all;
        n = m_n[m];
        span = 1 << m_pcw[m];
        if (st) begin
            for (int i = 0; i < n; i++) begin
                m_pc[m][i] = 0;
                m_halt[m][i] = 0;
            end
            m_last[m] = n - 1;
            m_v[m] = 0;
            return;
        end
        bt = bt % n;  ht = ht % n;  btg = btg % span;
        for (int i = 0; i < 16; i++) nh[i] = m_halt[m][i];
        if (hv) nh[ht] = 1;
        any = 0;
        will_all = 1;
        for (int i = 0; i < n; i++) begin
            if (!m_halt[m][i]) any = 1;
            if (!nh[i]) will_all = 0;
        end
        m_v[m] = 0;
        if (r && any && !will_all) begin
            for (int k = n; k >= 1; k--) begin
                t = (m_last[m] + k) % n;
                if (!m_halt[m][t]) m_tid[m] = t;
            end
            t = m_tid[m];
            m_v[m] = 1;
            m_addr[m] = t * span + m_pc[m][t];
            m_pc[m][t] = (m_pc[m][t] + 1) % span;
            m_last[m] = t;
        end
        if (bv) m_pc[m][bt] = btg;
        for (int i = 0; i < 16; i++) m_halt[m][i] = nh[i];
    endfunction

    function automatic int m_active(int m);
        int a = 0;
        for (int i = 0; i < m_n[m]; i++)
            if (!m_halt[m][i]) a |= (1 << i);
        return a;
    endfunction

    function automatic int m_done(int m);
        return (m_active(m) == 0) ? 1 : 0;
    endfunction

    task automatic check_models();
        chk("n4_valid", int'(v4), int'(m_v[0]));
        if (m_v[0]) begin
            chk("n4_tid", int'(tid4), m_tid[0]);
            chk("n4_addr", int'(addr4), m_addr[0]);
        end
        chk("n4_active", int'(act4), m_active(0));
        chk("n4_done", int'(done4), m_done(0));
        chk("n8_valid", int'(v8), int'(m_v[1]));
        if (m_v[1]) begin
            chk("n8_tid", int'(tid8), m_tid[1]);
            chk("n8_addr", int'(addr8), m_addr[1]);
        end
        chk("n8_active", int'(act8), m_active(1));
        chk("n8_done", int'(done8), m_done(1));
    endtask

    task automatic cyc(input bit st, input bit r, input bit bv, input int bt,
                       input int btg, input bit hv, input int ht);
        start      = st;
        run        = r;
        br_valid   = bv;
        halt_valid = hv;
        br_tid4    = bt[1:0];
        br_tid8    = bt[2:0];
        br_tgt4    = btg[6:0];
        br_tgt8    = btg[5:0];
        halt_tid4  = ht[1:0];
        halt_tid8  = ht[2:0];
        @(posedge clk);
        #1;
        m_step(0, st, r, bv, bt, btg, hv, ht);
        m_step(1, st, r, bv, bt, btg, hv, ht);
        check_models();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start = 0; run = 1; br_valid = 1; halt_valid = 1;
        br_tid4 = 1; br_tid8 = 1; br_tgt4 = 7'h33; br_tgt8 = 6'h13;
        halt_tid4 = 2; halt_tid8 = 2;
        @(posedge clk);
        #1;
        m_reset(0);
        m_reset(1);
        chk("rst_n4_valid", int'(v4), 0);
        chk("rst_n4_tid", int'(tid4), 0);
        chk("rst_n4_addr", int'(addr4), 0);
        chk("rst_n4_active", int'(act4), 'hF);
        chk("rst_n4_done", int'(done4), 0);
        chk("rst_n8_valid", int'(v8), 0);
        chk("rst_n8_tid", int'(tid8), 0);
        chk("rst_n8_addr", int'(addr8), 0);
        chk("rst_n8_active", int'(act8), 'hFF);
        chk("rst_n8_done", int'(done8), 0);
        rst = 1'b1;
        run = 0; br_valid = 0; halt_valid = 0;
    endtask

    typedef struct {
        bit run; bit hv; int ht; bit bv; int bt; int btg;
        bit ev; int et; int ea; int eact; bit ed;
    } vec_t;

    function automatic vec_t mk(bit r, bit hv, int ht, bit bv, int bt, int btg,
                                bit ev, int et, int ea, int eact, bit ed);
        vec_t v;
        v.run = r; v.hv = hv; v.ht = ht; v.bv = bv; v.bt = bt; v.btg = btg;
        v.ev = ev; v.et = et; v.ea = ea; v.eact = eact; v.ed = ed;
        return v;
    endfunction

    vec_t vecs [22];

    initial begin
        // 4-thread expectations, derived by hand from the issue rules
        vecs[0]  = mk(1,0,0, 0,0,0,    1,0,'h000,'hF,0);
        vecs[1]  = mk(1,0,0, 0,0,0,    1,1,'h080,'hF,0);
        vecs[2]  = mk(1,0,0, 0,0,0,    1,2,'h100,'hF,0);
        vecs[3]  = mk(1,0,0, 0,0,0,    1,3,'h180,'hF,0);
        vecs[4]  = mk(1,0,0, 0,0,0,    1,0,'h001,'hF,0);
        vecs[5]  = mk(1,1,1, 0,0,0,    1,1,'h081,'hD,0);
        vecs[6]  = mk(1,0,0, 0,0,0,    1,2,'h101,'hD,0);
        vecs[7]  = mk(1,0,0, 0,0,0,    1,3,'h181,'hD,0);
        vecs[8]  = mk(1,0,0, 0,0,0,    1,0,'h002,'hD,0);
        vecs[9]  = mk(1,0,0, 1,2,'h05, 1,2,'h102,'hD,0);
        vecs[10] = mk(1,0,0, 0,0,0,    1,3,'h182,'hD,0);
        vecs[11] = mk(1,0,0, 0,0,0,    1,0,'h003,'hD,0);
        vecs[12] = mk(1,0,0, 0,0,0,    1,2,'h105,'hD,0);
        vecs[13] = mk(1,0,0, 1,0,'h7F, 1,3,'h183,'hD,0);
        vecs[14] = mk(1,0,0, 0,0,0,    1,0,'h07F,'hD,0);
        vecs[15] = mk(1,0,0, 0,0,0,    1,2,'h106,'hD,0);
        vecs[16] = mk(1,0,0, 0,0,0,    1,3,'h184,'hD,0);
        vecs[17] = mk(1,0,0, 0,0,0,    1,0,'h000,'hD,0);
        vecs[18] = mk(1,1,0, 0,0,0,    1,2,'h107,'hC,0);
        vecs[19] = mk(1,1,2, 0,0,0,    1,3,'h185,'h8,0);
        vecs[20] = mk(1,1,3, 0,0,0,    0,0,0,     'h0,1);
        vecs[21] = mk(1,0,0, 0,0,0,    0,0,0,     'h0,1);

        rst = 1'b0;
        start = 0; run = 0; br_valid = 0; halt_valid = 0;
        br_tid4 = 0; br_tid8 = 0; br_tgt4 = 0; br_tgt8 = 0;
        halt_tid4 = 0; halt_tid8 = 0;
        @(negedge clk);
        do_reset();

        // Rotation, halt skipping, redirect-wins, PC wrap, full completion
        for (int i = 0; i < 22; i++) begin
            cyc(0, vecs[i].run, vecs[i].bv, vecs[i].bt, vecs[i].btg, vecs[i].hv, vecs[i].ht);
            chk($sformatf("vec%0d_valid", i), int'(v4), int'(vecs[i].ev));
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_tid", i), int'(tid4), vecs[i].et);
                chk($sformatf("vec%0d_addr", i), int'(addr4), vecs[i].ea);
            end
            chk($sformatf("vec%0d_active", i), int'(act4), vecs[i].eact);
            chk($sformatf("vec%0d_done", i), int'(done4), int'(vecs[i].ed));
        end

        // start with a same-cycle halt: halt ignored, rotation restarts at 0
        cyc(1, 1, 0, 0, 0, 1, 2);
        chk("start_valid", int'(v4), 0);
        chk("start_active", int'(act4), 'hF);
        chk("start_done", int'(done4), 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("post_start_valid", int'(v4), 1);
        chk("post_start_tid", int'(tid4), 0);
        chk("post_start_addr", int'(addr4), 'h000);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("post_start_addr2", int'(addr4), 'h080);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("run_drop_valid", int'(v4), 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("run_resume_addr", int'(addr4), 'h100);

        // 8-thread rotation after reset: addr = {tid, 6-bit pc}
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            chk("n8_rot_tid", int'(tid8), i % 8);
            chk("n8_rot_addr", int'(addr8), ((i % 8) << 6) | (i / 8));
        end

        // Mid-run reset returns to power-up behaviour
        do_reset();
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("after_rst_tid", int'(tid4), 0);
        chk("after_rst_addr", int'(addr4), 0);
        chk("after_rst_addr8", int'(addr8), 0);

        // Randomised traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 85,
                    $urandom_range(0, 99) < 15,
                    int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 127)),
                    $urandom_range(0, 99) < 8,
                    int'($urandom_range(0, 7)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
